vend_txn_controller: RTL
========================

Name: vend_txn_controller

Overview:
- Transaction sequencer for the vending machine.
- Accumulates coin credit, checks a product selection against per-product prices, and drives the dispense mechanism through a req/ack handshake.
- Returns change and refunds one 5-unit coin at a time through a second req/ack handshake.
- Sits between the coin acceptor/keypad front end and the dispense/coin-return actuators.

Parameters:
PRICE_0, 15, price of product 0 (multiple of 5)
PRICE_1, 25, price of product 1 (multiple of 5)
CREDIT_W, 6, width of the credit register
MAX_CREDIT, 40, highest credit accepted (multiple of 5, must be below 2**CREDIT_W)
TIMEOUT, 255, idle cycles in COLLECT before an automatic refund

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
coin  in  2  coin code, valid each cycle: 00 none, 10 = 5, 11 = 10, 01 invalid (ignored, no reject)
sel_valid  in  1  one-cycle selection strobe
sel_id  in  1  selected product
cancel  in  1  one-cycle refund request
disp_req  out  1  dispense request; held until acknowledged
disp_id  out  1  product to dispense; stable while disp_req is high
disp_ack  in  1  dispense done
chg_req  out  1  request to return one 5-unit coin
chg_ack  in  1  coin returned
credit  out  CREDIT_W  current credit
busy  out  1  high in DISPENSE or CHANGE
coin_reject  out  1  one-cycle pulse: a valid coin was not credited
sel_denied  out  1  one-cycle pulse: selection refused for insufficient credit

Behaviour:
- Reset (async, active-high): state IDLE; credit, timer and all outputs 0. Reset mid-transaction discards credit. Outputs are forced low immediately, without waiting for a clock.
- All outputs are registered. A coin presented in cycle n is reflected in credit at n+1.
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- IDLE:
  - Valid coin: credit = value; go to COLLECT.
  - sel_valid: pulses sel_denied.
  - cancel: ignored.
- COLLECT, priority order cancel > selection > coin:
  - cancel: go to CHANGE. A same-cycle coin is rejected.
  - sel_valid: compare the pre-cycle credit with PRICE[sel_id].
    - If credit >= price: credit -= price, latch disp_id, go to DISPENSE. A same-cycle coin is rejected.
    - Otherwise: pulse sel_denied and stay in COLLECT. A same-cycle coin is still processed normally.
  - Coin: if credit + value > MAX_CREDIT, pulse coin_reject and leave credit unchanged; else credit += value.
  - Timer: cleared on every accepted coin, otherwise increments. When it reaches TIMEOUT, go to CHANGE (refund).
- DISPENSE:
  - disp_req = 1 from the first cycle in the state until the cycle disp_ack is sampled high.
  - On ack: disp_req drops next cycle; go to CHANGE if credit > 0, else IDLE.
  - All coins rejected.
- CHANGE:
  - chg_req = 1 while credit > 0.
  - Each sampled chg_ack: credit -= 5.
  - When credit reaches 0: chg_req drops the same cycle credit becomes 0; go to IDLE.
  - All coins rejected; sel_valid and cancel ignored.
- disp_ack or chg_ack while the matching req is low: ignored.
- Credit never underflows or overflows; arithmetic is done at CREDIT_W+1 bits before the compare.
- busy = (state == DISPENSE or CHANGE).

Decomposition:
- vend_pkg holds:
  - coin code constants: COIN_NONE = 00, COIN_5 = 10, COIN_10 = 11;
  - coin values: 5, 10;
  - the state enum;
  - a function coin_value(code), returning 0 for none or invalid codes.
- Sub-module vend_timeout_timer: counter with clear and enable inputs and an expired output; width = clog2(TIMEOUT+1).

Test Plan:
- rst pulse; coin 11, coin 10, sel_valid sel_id=0 -> credit 10, then 15, then 0; disp_req=1 with disp_id=0 until disp_ack; then IDLE, chg_req never asserted.
- Coins 11, 11; sel_id=0 -> credit 5 after the sale; disp handshake; then chg_req=1; chg_ack once -> credit 0, chg_req=0, IDLE.
- Credit 15; sel_id=1 -> sel_denied pulse, credit stays 15, state COLLECT. Same cycle with coin 11 -> credit 25.
- Coins to 40; coin 10 -> coin_reject, credit 40. cancel -> 8 chg_req/chg_ack exchanges, credit 40→0, IDLE.
- Coin 10 then no activity for TIMEOUT cycles -> CHANGE entered, one chg_req, refund complete. Coin during CHANGE -> coin_reject.
- rst asserted between clock edges during DISPENSE -> disp_req, busy and credit go to 0 before the next edge; a later disp_ack is ignored.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and coin helpers for the vending transaction controller.
// Exports coin codes and values, the controller state enum and coin_value().
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b10;
    localparam logic [1:0] COIN_10   = 2'b11;

    localparam int unsigned COIN_5_VAL  = 5;
    localparam int unsigned COIN_10_VAL = 10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DISPENSE,
        S_CHANGE
    } state_e;

    // Invalid code 01 and COIN_NONE both carry no value.
    function automatic logic [3:0] coin_value(input logic [1:0] code);
        case (code)
            COIN_5:  return 4'(COIN_5_VAL);
            COIN_10: return 4'(COIN_10_VAL);
            default: return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_txn_controller_if.sv
// Front-end / actuator bundle of the vending transaction controller.
// master: keypad, coin acceptor and actuators; slave: the controller.
interface vend_txn_controller_if #(
    parameter int CREDIT_W = 6
);
    logic [1:0]          coin;
    logic                sel_valid;
    logic                sel_id;
    logic                cancel;
    logic                disp_req;
    logic                disp_id;
    logic                disp_ack;
    logic                chg_req;
    logic                chg_ack;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                coin_reject;
    logic                sel_denied;

    modport master (
        output coin, sel_valid, sel_id, cancel, disp_ack, chg_ack,
        input  disp_req, disp_id, chg_req, credit, busy,
        input  coin_reject, sel_denied
    );

    modport slave (
        input  coin, sel_valid, sel_id, cancel, disp_ack, chg_ack,
        output disp_req, disp_id, chg_req, credit, busy,
        output coin_reject, sel_denied
    );
endinterface

// File: rtl/vend_timeout_timer.sv
// Idle timer for the COLLECT state; saturates at TIMEOUT.
// Ports: clk, rst, clr_i (clear), en_i (count), expired_o (count hits TIMEOUT this edge).
module vend_timeout_timer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int unsigned W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (en_i && cnt_q != W'(TIMEOUT))
            cnt_d = cnt_q + 1'b1;
    end

    // Flags the edge on which the count reaches TIMEOUT, so the owner
    // leaves after exactly TIMEOUT uncleared enabled cycles.
    assign expired_o = en_i && (cnt_d == W'(TIMEOUT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/vend_txn_controller.sv
// Vending transaction sequencer: credit, selection, dispense and change.
// Ports: clk, rst (async high), txn (slave side of vend_txn_controller_if).
module vend_txn_controller
    import vend_pkg::*;
#(
    parameter int unsigned PRICE_0    = 15,
    parameter int unsigned PRICE_1    = 25,
    parameter int          CREDIT_W   = 6,
    parameter int unsigned MAX_CREDIT = 40,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    vend_txn_controller_if.slave  txn
);
    localparam int CW1 = CREDIT_W + 1;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                disp_id_q, disp_id_d;
    logic                disp_req_q, chg_req_q, busy_q;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_denied_q, sel_denied_d;

    logic [CW1-1:0] cval, cur, sum, price;
    logic           coin_vld, sale_ok, fits, coin_acc;
    logic           tmr_clr, tmr_en, tmr_exp;

    // Arithmetic one bit wider than credit so overflow is visible.
    assign cval     = CW1'(coin_value(txn.coin));
    assign coin_vld = (cval != '0);
    assign cur      = {1'b0, credit_q};
    assign sum      = cur + cval;
    assign price    = txn.sel_id ? CW1'(PRICE_1) : CW1'(PRICE_0);
    assign sale_ok  = txn.sel_valid && (cur >= price);
    assign fits     = (sum <= CW1'(MAX_CREDIT));

    assign coin_acc = coin_vld &&
        ((state_q == S_IDLE) ||
         (state_q == S_COLLECT && !txn.cancel && !sale_ok && fits));

    assign tmr_en  = (state_q == S_COLLECT);
    assign tmr_clr = coin_acc || (state_q != S_COLLECT);

    vend_timeout_timer #(.TIMEOUT(TIMEOUT)) u_tmr (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (tmr_clr),
        .en_i      (tmr_en),
        .expired_o (tmr_exp)
    );

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        disp_id_d     = disp_id_q;
        coin_reject_d = 1'b0;
        sel_denied_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                sel_denied_d = txn.sel_valid;
                if (coin_vld) begin
                    credit_d = cval[CREDIT_W-1:0];
                    state_d  = S_COLLECT;
                end
            end
            S_COLLECT: begin
                if (txn.cancel) begin
                    coin_reject_d = coin_vld;
                    state_d       = S_CHANGE;
                end else if (sale_ok) begin
                    credit_d      = CREDIT_W'(cur - price);
                    disp_id_d     = txn.sel_id;
                    coin_reject_d = coin_vld;
                    state_d       = S_DISPENSE;
                end else begin
                    sel_denied_d  = txn.sel_valid;
                    coin_reject_d = coin_vld && !fits;
                    if (coin_acc)
                        credit_d = sum[CREDIT_W-1:0];
                    if (tmr_exp)
                        state_d = S_CHANGE;
                end
            end
            S_DISPENSE: begin
                coin_reject_d = coin_vld;
                if (txn.disp_ack && disp_req_q)
                    state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                coin_reject_d = coin_vld;
                if (credit_q == '0) begin
                    state_d = S_IDLE;
                end else if (txn.chg_ack && chg_req_q) begin
                    credit_d = CREDIT_W'(cur - CW1'(COIN_5_VAL));
                    if (cur == CW1'(COIN_5_VAL))
                        state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Request outputs follow the next state so they rise on state entry
    // and chg_req falls on the same edge credit reaches zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            disp_id_q     <= 1'b0;
            disp_req_q    <= 1'b0;
            chg_req_q     <= 1'b0;
            busy_q        <= 1'b0;
            coin_reject_q <= 1'b0;
            sel_denied_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_id_q     <= disp_id_d;
            disp_req_q    <= (state_d == S_DISPENSE);
            chg_req_q     <= (state_d == S_CHANGE) && (credit_d != '0);
            busy_q        <= (state_d == S_DISPENSE) || (state_d == S_CHANGE);
            coin_reject_q <= coin_reject_d;
            sel_denied_q  <= sel_denied_d;
        end
    end

    assign txn.credit      = credit_q;
    assign txn.disp_req    = disp_req_q;
    assign txn.disp_id     = disp_id_q;
    assign txn.chg_req     = chg_req_q;
    assign txn.busy        = busy_q;
    assign txn.coin_reject = coin_reject_q;
    assign txn.sel_denied  = sel_denied_q;

endmodule
